// File: rtl/led_pattern_gen.sv
// LED pattern engine: divides CLOCK_50 to a step tick and drives LEDG in BLINK, CHASE,
// BOUNCE or PWM BREATHE mode. The tick is exported for other blocks.
module led_pattern_gen #(
   parameter int unsigned CLK_HZ   = 50_000_000,
   parameter int unsigned TICK_HZ  = 2,
   parameter int unsigned N_LEDS   = 8,
   parameter int unsigned PWM_BITS = 8,
   parameter int unsigned DUTY_DIV = 1024
) (
   input  logic              CLOCK_50,
   input  logic              KEY0,
   input  logic              enable,
   input  logic [1:0]        mode,
   output logic [N_LEDS-1:0] LEDG,
   output logic              tick
);

   localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
   localparam int unsigned PRE_W = $clog2(DIV);
   localparam int unsigned DD_W  = (DUTY_DIV > 1) ? $clog2(DUTY_DIV) : 1;
   localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

   typedef enum logic [1:0] {
      ModeBlink   = 2'b00,
      ModeChase   = 2'b01,
      ModeBounce  = 2'b10,
      ModeBreathe = 2'b11
   } mode_e;

   logic [1:0]          mode_m_q, mode_s_q;
   mode_e               mode_q, mode_d;
   logic [PRE_W-1:0]    presc_q, presc_d;
   logic                tick_q, tick_d;
   logic [N_LEDS-1:0]   pattern_q, pattern_d;
   logic                dir_q, dir_d;          // 0 = left (towards MSB)
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic                duty_dir_q, duty_dir_d; // 0 = up
   logic [PWM_BITS-1:0] pwm_q, pwm_d;
   logic [DD_W-1:0]     ddiv_q, ddiv_d;
   logic [N_LEDS-1:0]   led_q, led_d;
   logic                mode_chg;

   always_ff @(posedge CLOCK_50 or negedge KEY0) begin
      if (!KEY0) begin
         mode_m_q   <= 2'b00;
         mode_s_q   <= 2'b00;
         mode_q     <= ModeBlink;
         presc_q    <= '0;
         tick_q     <= 1'b0;
         pattern_q  <= '0;
         dir_q      <= 1'b0;
         duty_q     <= '0;
         duty_dir_q <= 1'b0;
         pwm_q      <= '0;
         ddiv_q     <= '0;
         led_q      <= '0;
      end else begin
         mode_m_q   <= mode;
         mode_s_q   <= mode_m_q;
         mode_q     <= mode_d;
         presc_q    <= presc_d;
         tick_q     <= tick_d;
         pattern_q  <= pattern_d;
         dir_q      <= dir_d;
         duty_q     <= duty_d;
         duty_dir_q <= duty_dir_d;
         pwm_q      <= pwm_d;
         ddiv_q     <= ddiv_d;
         led_q      <= led_d;
      end
   end

   assign mode_chg = (mode_e'(mode_s_q) != mode_q);

   always_comb begin
      mode_d     = mode_q;
      presc_d    = presc_q;
      tick_d     = 1'b0;
      pattern_d  = pattern_q;
      dir_d      = dir_q;
      duty_d     = duty_q;
      duty_dir_d = duty_dir_q;
      pwm_d      = pwm_q;
      ddiv_d     = ddiv_q;
      led_d      = led_q;

      if (mode_chg) begin
         // A mode change re-initialises everything and suppresses any pending step.
         mode_d     = mode_e'(mode_s_q);
         presc_d    = '0;
         dir_d      = 1'b0;
         duty_d     = '0;
         duty_dir_d = 1'b0;
         pwm_d      = '0;
         ddiv_d     = '0;
         if (mode_d == ModeChase || mode_d == ModeBounce) begin
            pattern_d = N_LEDS'(1);
         end else begin
            pattern_d = '0;
         end
         led_d = pattern_d;
      end else if (enable) begin
         pwm_d = pwm_q + 1'b1;

         if (ddiv_q == DD_W'(DUTY_DIV - 1)) begin
            ddiv_d = '0;
            if (!duty_dir_q) begin
               duty_d = duty_q + 1'b1;
               if (duty_d == DUTY_MAX) duty_dir_d = 1'b1;
            end else begin
               duty_d = duty_q - 1'b1;
               if (duty_d == '0) duty_dir_d = 1'b0;
            end
         end else begin
            ddiv_d = ddiv_q + 1'b1;
         end

         if (presc_q == PRE_W'(DIV - 1)) begin
            presc_d = '0;
            tick_d  = 1'b1;
            unique case (mode_q)
               ModeBlink: pattern_d = ~pattern_q;
               ModeChase: pattern_d = (pattern_q << 1) | (pattern_q >> (N_LEDS - 1));
               ModeBounce: begin
                  // Direction flips on the step that reaches an end, so end LEDs never repeat.
                  if (N_LEDS == 1) begin
                     pattern_d = pattern_q;
                  end else if (!dir_q) begin
                     pattern_d = pattern_q << 1;
                     if (pattern_d[N_LEDS-1]) dir_d = 1'b1;
                  end else begin
                     pattern_d = pattern_q >> 1;
                     if (pattern_d[0]) dir_d = 1'b0;
                  end
               end
               ModeBreathe: pattern_d = pattern_q;
               default: pattern_d = pattern_q;
            endcase
         end else begin
            presc_d = presc_q + 1'b1;
         end

         if (mode_q == ModeBreathe) begin
            led_d = (pwm_q < duty_q) ? '1 : '0;
         end else begin
            led_d = pattern_d;
         end
      end
   end

   assign LEDG = led_q;
   assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomised scoreboard bench for led_pattern_gen: stimulus pushes the expected LEDG/tick per
// clock from an arithmetic model; a negedge monitor pops and compares.
module tb_led_pattern_gen;

   localparam int unsigned N = 4;

   logic         CLOCK_50;
   logic         KEY0;
   logic         enable;
   logic [1:0]   mode;
   logic [N-1:0] LEDG;
   logic         tick;

   led_pattern_gen #(
      .CLK_HZ  (20),
      .TICK_HZ (2),
      .N_LEDS  (N),
      .PWM_BITS(3),
      .DUTY_DIV(2)
   ) dut (
      .CLOCK_50(CLOCK_50),
      .KEY0    (KEY0),
      .enable  (enable),
      .mode    (mode),
      .LEDG    (LEDG),
      .tick    (tick)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   int cyc = 0;
   always @(posedge CLOCK_50) cyc <= cyc + 1;

   typedef struct {
      int           cyc;
      logic [N-1:0] led;
      logic         tick;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Reference model state: active mode and enabled clocks since it took effect.
   logic [1:0]   act;
   int           ecount;
   logic [N-1:0] led_m;
   logic         tick_m;
   logic [1:0]   d1, d2;

   function automatic int tri_wave(input int s);
      int r;
      r = s % 14;
      return (r <= 7) ? r : 14 - r;
   endfunction

   function automatic logic [N-1:0] exp_led(input logic [1:0] m, input int e);
      int k, p;
      logic [N-1:0] one;
      one = 1;
      k = e / 10;
      case (m)
         2'b00: return (k % 2 == 1) ? '1 : '0;
         2'b01: return one << (k % 4);
         2'b10: begin
            p = k % 6;
            return one << ((p < 4) ? p : 6 - p);
         end
         default: begin
            if (e == 0) return '0;
            return (((e - 1) % 8) < tri_wave((e - 1) / 2)) ? '1 : '0;
         end
      endcase
   endfunction

   task automatic model_reset();
      act = 2'b00; ecount = 0; led_m = '0; d1 = 2'b00; d2 = 2'b00;
   endtask

   task automatic step(input logic en_v, input logic [1:0] mode_v);
      logic [1:0] ms;
      enable = en_v;
      mode   = mode_v;
      @(posedge CLOCK_50);
      #1;
      ms = d2; d2 = d1; d1 = mode_v;
      if (ms != act) begin
         act = ms; ecount = 0; tick_m = 1'b0; led_m = exp_led(act, 0);
      end else if (en_v) begin
         ecount++;
         tick_m = (ecount % 10 == 0);
         led_m  = exp_led(act, ecount);
      end else begin
         tick_m = 1'b0;
      end
      sb.push_back('{cyc: cyc, led: led_m, tick: tick_m});
   endtask

   task automatic check_reset(input string name);
      n_vec++;
      if (LEDG !== '0 || tick !== 1'b0) begin
         n_err++;
         $display("FAIL %s: LEDG=%b tick=%b, required LEDG=0000 tick=0", name, LEDG, tick);
      end
   endtask

   task automatic mid_reset();
      @(negedge CLOCK_50);
      #1 KEY0 = 1'b0;
      #1 check_reset("async_reset");
      @(posedge CLOCK_50);
      @(posedge CLOCK_50);
      #1 check_reset("reset_held");
      @(negedge CLOCK_50);
      #1 KEY0 = 1'b1;
      model_reset();
   endtask

   // Monitor: compare against the scoreboard entry stamped with this cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLOCK_50);
         if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            n_vec++;
            if (LEDG !== e.led || tick !== e.tick) begin
               n_err++;
               $display("FAIL cycle %0d: LEDG=%b tick=%b, required LEDG=%b tick=%b",
                        cyc, LEDG, tick, e.led, e.tick);
            end
         end else if (tick !== 1'b0) begin
            n_vec++;
            n_err++;
            $display("FAIL stray_tick cycle %0d: tick=%b, required 0", cyc, tick);
         end
      end
   end

   initial begin
      logic [1:0] cur;
      KEY0 = 1'b0; enable = 1'b0; mode = 2'b00;
      model_reset();
      #3 check_reset("power_on_reset");
      @(negedge CLOCK_50);
      #1 KEY0 = 1'b1;

      // BLINK, then asynchronous reset mid-run and BLINK again
      repeat (35) step(1'b1, 2'b00);
      mid_reset();
      repeat (25) step(1'b1, 2'b00);

      // CHASE through a full wrap
      repeat (60) step(1'b1, 2'b01);

      // BOUNCE through more than one round trip, with a freeze mid-pattern
      repeat (45) step(1'b1, 2'b10);
      repeat (25) step(1'b0, 2'b10);
      repeat (50) step(1'b1, 2'b10);

      // CHASE -> BOUNCE landing on the clock where the prescaler would wrap
      repeat (15) step(1'b1, 2'b01);
      for (int i = 0; i < 20 && (act != 2'b01 || ecount % 10 != 7); i++) step(1'b1, 2'b01);
      repeat (25) step(1'b1, 2'b10);

      // BREATHE: full duty triangle, then with enable gaps
      repeat (70) step(1'b1, 2'b11);
      repeat (60) step(($urandom_range(0, 3) != 0), 2'b11);

      // Random modes, enable gaps and one-clock mode glitches
      cur = 2'b00;
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 39) == 0) cur = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 59) == 0) step(1'b1, 2'($urandom_range(0, 3)));
         else step(($urandom_range(0, 7) != 0), cur);
      end
      mid_reset();
      repeat (30) step(1'b1, 2'b11);

      repeat (3) @(posedge CLOCK_50);
      #1;
      n_vec++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
